shift_issue_reg: RTL

- ID→EX issue register for shift instructions; sits directly upstream of the combinational shifter (`funct[1:0]`, `a[31:0]`, `N[4:0]`).
- Decodes a MIPS R-type instruction plus register-file operands into shifter controls.
- Holds them in a valid/ready pipeline register with stall, flush and optional skid buffering, so the shifter sees stable operands for the whole EX cycle.

---
 rtl/shift_issue_reg.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/shift_issue_reg.sv
// shift_issue_reg: ID->EX issue register for MIPS shift instructions.
// Decodes an R-type instruction plus register operands into controls for the
// downstream combinational shifter, and holds them in a valid/ready register.
// Build option: define SHIFT_ISSUE_SKID_EN for a 2-entry skid buffer with a
// registered in_ready; otherwise a single-entry register with a
// combinational in_ready is built.
module shift_issue_reg #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  sh_funct,
    output logic [31:0] sh_a,
    output logic [4:0]  sh_n,
    output logic        is_shift,
    output logic [4:0]  rd
);

    // The skid buffer is hard-wired to two entries.
    if (DEPTH != 2) begin : g_depth_chk
        $error("shift_issue_reg: DEPTH must be 2");
    end

    typedef struct packed {
        logic        is_shift;
        logic [1:0]  funct;
        logic [31:0] a;
        logic [4:0]  n;
        logic [4:0]  rd;
    } entry_t;

    // Shifter op encodings.
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    // Non-shift instructions (including the all-zero NOP, which is
    // architecturally SLL $0,$0,0) produce a zeroed shifter payload so EX
    // never sees stale operands on a bubble-like entry.
    function automatic entry_t decode_entry(input logic [31:0] ins,
                                            input logic [31:0] rs,
                                            input logic [31:0] rt);
        entry_t e;
        e    = '0;
        e.rd = ins[15:11];
        if ((ins[31:26] == 6'd0) && (ins != 32'd0)) begin
            case (ins[5:0])
                6'b000000: begin e.is_shift = 1'b1; e.funct = OP_SLL; e.n = ins[10:6]; end
                6'b000010: begin e.is_shift = 1'b1; e.funct = OP_SRL; e.n = ins[10:6]; end
                6'b000011: begin e.is_shift = 1'b1; e.funct = OP_SRA; e.n = ins[10:6]; end
                6'b000100: begin e.is_shift = 1'b1; e.funct = OP_SLL; e.n = rs[4:0];   end
                6'b000110: begin e.is_shift = 1'b1; e.funct = OP_SRL; e.n = rs[4:0];   end
                6'b000111: begin e.is_shift = 1'b1; e.funct = OP_SRA; e.n = rs[4:0];   end
                default:   e.is_shift = 1'b0;
            endcase
            if (e.is_shift) begin
                e.a = rt;
            end
        end
        return e;
    endfunction

    // Register-number fields and the upper rs bits never influence the
    // shifter controls; they are gathered here so lint sees them consumed.
    logic unused_bits;
    assign unused_bits = ^{instr[25:16], rs_data[31:5]};

    // ---- stage p0: decode of the offered instruction ----
    entry_t dec_p0;
    logic   push_p0;
    logic   pop_p0;

    assign dec_p0 = decode_entry(instr, rs_data, rt_data);

    // ---- stage p1: issue register(s) presented to EX ----
    entry_t head_p1;
    logic   vld_p1;

`ifdef SHIFT_ISSUE_SKID_EN
    entry_t skid_p1;
    logic   skid_vld_p1;
    logic   ready_p1;

    assign in_ready = ready_p1;
    assign push_p0  = in_valid && ready_p1 && !flush;
    assign pop_p0   = vld_p1 && out_ready;

    // Occupancy and registered ready; push with a full buffer cannot occur
    // because ready_p1 is low whenever the skid slot is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            ready_p1    <= 1'b1;
        end else if (flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            ready_p1    <= 1'b1;
        end else begin
            case ({push_p0, pop_p0})
                2'b10: begin
                    if (!vld_p1) begin
                        vld_p1 <= 1'b1;
                    end else begin
                        skid_vld_p1 <= 1'b1;
                        ready_p1    <= 1'b0;
                    end
                end
                2'b01: begin
                    if (skid_vld_p1) begin
                        skid_vld_p1 <= 1'b0;
                        ready_p1    <= 1'b1;
                    end else begin
                        vld_p1 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload movement: new data lands in the head when it is empty or being
    // drained, otherwise in the skid slot; a pop promotes the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_p1 <= '0;
            skid_p1 <= '0;
        end else if (!flush) begin
            if (push_p0 && (!vld_p1 || pop_p0)) begin
                head_p1 <= dec_p0;
            end else if (pop_p0 && skid_vld_p1) begin
                head_p1 <= skid_p1;
            end
            if (push_p0 && vld_p1 && !pop_p0) begin
                skid_p1 <= dec_p0;
            end
        end
    end
`else
    assign in_ready = !vld_p1 || out_ready;
    assign push_p0  = in_valid && in_ready && !flush;
    assign pop_p0   = vld_p1 && out_ready;

    // Single-entry valid flag; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (push_p0) begin
            vld_p1 <= 1'b1;
        end else if (pop_p0) begin
            vld_p1 <= 1'b0;
        end
    end

    // Payload captured on accept and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_p1 <= '0;
        end else if (push_p0) begin
            head_p1 <= dec_p0;
        end
    end
`endif

    assign out_valid = vld_p1;
    assign is_shift  = head_p1.is_shift;
    assign sh_funct  = head_p1.funct;
    assign sh_a      = head_p1.a;
    assign sh_n      = head_p1.n;
    assign rd        = head_p1.rd;

endmodule
